// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the 4:1 mux select path and holds it for one owner's whole transaction.
// Latency: grant/select/busy valid one cycle after req is sampled in IDLE; release one cycle after owner drops req.
// Backpressure: none; requesters hold req high until they are granted and for as long as they need the mux.
//
// Ports:
//   clock   - single clock, all state on the rising edge
//   reset   - synchronous active-low reset
//   req     - request lines, bit i = requester i wants the mux
//   grant   - one-hot (or zero) ownership, registered
//   select  - registered 2-bit mux select, index of current or last owner
//   busy    - high while any grant bit is high
//   expired - one-cycle pulse when a grant is revoked by the hold timeout
//
// Build option: define MUX_ARB_TIMEOUT_EN to enable the MAX_HOLD hold counter
// and revocation. Without it the owner keeps the mux until it drops req and
// expired is tied low.

module mux_rr_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] select,
    output logic       busy,
    output logic       expired
);

    // Elaboration-time guard: the hold counter is 8 bits wide.
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux_rr_arbiter: MAX_HOLD must be in 2..255");
    end

    typedef enum logic {
        S_IDLE,
        S_OWN
    } state_t;

    state_t     state_q;
    logic [3:0] grant_q;
    logic [1:0] select_q;
    logic [1:0] last_q;
    logic       busy_q;

    // Next winner, searched from (last+1) mod 4 upward with wrap.
    logic       pick_vld_d;
    logic [1:0] pick_idx_d;
    logic [1:0] cand;

`ifdef MUX_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] cnt_q;
    logic       expired_q;
    logic       hold_done;

    assign hold_done = (cnt_q == HOLD_LAST);
    assign expired   = expired_q;
`else
    assign expired   = 1'b0;
`endif

    // Walk the rotation from farthest to nearest so the nearest requester
    // (the one right after the last owner) is the value left standing.
    always_comb begin
        pick_vld_d = 1'b0;
        pick_idx_d = last_q;
        cand       = '0;
        for (int k = 3; k >= 0; k--) begin
            cand = last_q + 2'(k + 1);
            if (req[cand]) begin
                pick_vld_d = 1'b1;
                pick_idx_d = cand;
            end
        end
    end

    // select_q doubles as the owner index while in S_OWN; it is only ever
    // written on the edge that issues a new grant, so the mux stays steady
    // through the whole ownership and the following idle period.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            select_q  <= '0;
            busy_q    <= 1'b0;
            last_q    <= 2'd3;
`ifdef MUX_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            expired_q <= 1'b0;
`endif
        end else begin
`ifdef MUX_ARB_TIMEOUT_EN
            expired_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (pick_vld_d) begin
                        grant_q  <= 4'b0001 << pick_idx_d;
                        select_q <= pick_idx_d;
                        busy_q   <= 1'b1;
                        last_q   <= pick_idx_d;
`ifdef MUX_ARB_TIMEOUT_EN
                        cnt_q    <= '0;
`endif
                        state_q  <= S_OWN;
                    end
                end
                S_OWN: begin
                    if (!req[select_q]) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
`ifdef MUX_ARB_TIMEOUT_EN
                    else if (hold_done) begin
                        // Revoke; the owner re-enters the rotation behind
                        // everyone else because last_q already points at it.
                        grant_q   <= '0;
                        busy_q    <= 1'b0;
                        expired_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign grant  = grant_q;
    assign select = select_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] select;
    logic       busy;
    logic       expired;

    int tests;
    int fails;

    mux_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .grant   (grant),
        .select  (select),
        .busy    (busy),
        .expired (expired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle; inputs changed after this are
    // sampled on the next edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                           input logic b, input logic e);
        chk({tag, ".grant"},   grant,          g);
        chk({tag, ".select"},  {2'b00, select}, {2'b00, s});
        chk({tag, ".busy"},    {3'b000, busy},  {3'b000, b});
        chk({tag, ".expired"}, {3'b000, expired}, {3'b000, e});
    endtask

    initial begin
        logic [3:0] onehot;
        tests = 0;
        fails = 0;
        reset = 1'b0;
        req   = 4'b0000;

        // Reset for two edges.
        tick();
        tick();
        chk_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        reset = 1'b1;

        // Single request, then release; select must keep its value.
        req = 4'b0100;
        tick();
        chk_out("single_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        chk_out("single_release", 4'b0000, 2'd2, 1'b0, 1'b0);
        tick();
        chk_out("idle_hold", 4'b0000, 2'd2, 1'b0, 1'b0);

        // Make 3 the last owner, then check wrap prefers 1 over 3.
        req = 4'b1000;
        tick();
        chk_out("own3", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        chk_out("rel3", 4'b0000, 2'd3, 1'b0, 1'b0);
        req = 4'b1010;
        tick();
        chk_out("wrap", 4'b0010, 2'd1, 1'b1, 1'b0);
        // Non-owner request changes are ignored while owning.
        req = 4'b0011;
        tick();
        chk_out("wrap_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        chk_out("wrap_rel", 4'b0000, 2'd1, 1'b0, 1'b0);

        // Grant 2 (search starts at 2 after last=1), then reset mid-grant.
        req = 4'b0100;
        tick();
        chk_out("pre_reset", 4'b0100, 2'd2, 1'b1, 1'b0);
        req   = 4'b1111;
        reset = 1'b0;
        tick();
        chk_out("mid_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        reset = 1'b1;

        // Full contention: each owner holds 3 cycles, drops for one, reasserts.
        for (int i = 0; i < 5; i++) begin
            onehot = 4'b0001 << (i % 4);
            tick();
            chk_out($sformatf("fair%0d_c1", i), onehot, 2'(i % 4), 1'b1, 1'b0);
            tick();
            chk_out($sformatf("fair%0d_c2", i), onehot, 2'(i % 4), 1'b1, 1'b0);
            tick();
            chk_out($sformatf("fair%0d_c3", i), onehot, 2'(i % 4), 1'b1, 1'b0);
            req = 4'b1111 & ~onehot;
            tick();
            chk_out($sformatf("fair%0d_gap", i), 4'b0000, 2'(i % 4), 1'b0, 1'b0);
            req = 4'b1111;
        end

        // Fresh reset so requester 0 wins first.
        req   = 4'b0011;
        reset = 1'b0;
        tick();
        chk_out("reset2", 4'b0000, 2'd0, 1'b0, 1'b0);
        reset = 1'b1;

`ifdef MUX_ARB_TIMEOUT_EN
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk_out($sformatf("to_hold%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        tick();
        chk_out("to_expire", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick();
        chk_out("to_next", 4'b0010, 2'd1, 1'b1, 1'b0);
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk_out($sformatf("to_next_hold%0d", c), 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        tick();
        chk_out("to_expire2", 4'b0000, 2'd1, 1'b0, 1'b1);
`else
        for (int c = 1; c <= 50; c++) begin
            tick();
            chk_out($sformatf("noto%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
`endif

        req = 4'b0000;
        tick();
        tick();
        chk({"final_idle", ".grant"}, grant, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
